// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester (IDLE/SETUP/ACCESS sequencer)
// that chains back-to-back commands without returning to IDLE.
// Optional feature macro: APB_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout
// that aborts the transfer and reports it through rsp_err.
// Ports:
//   pclk, preset          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid             one-cycle completion pulse; rsp_rdata, rsp_err
//   psel/pen/pwrite/paddr/pwdata   APB request side
//   prdata/pready                  APB completion side
module apb_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  pen,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   done;
    logic   accept;
    logic   abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] tcnt;

    // Fires in the TIMEOUT-th consecutive ACCESS cycle without pready.
    assign abort = (state == ACCESS) && !pready
                && (tcnt == 8'(TIMEOUT - 1));

    // Held at zero outside ACCESS, so it restarts on every ACCESS entry.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt    <= 8'd0;
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= abort;
            if (state != ACCESS)
                tcnt <= 8'd0;
            else if (!pready)
                tcnt <= tcnt + 8'd1;
        end
    end
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        psel      = 1'b0;
        pen       = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = !preset;
                accept    = cmd_valid && cmd_ready;
                if (accept)
                    state_nx = SETUP;
            end
            SETUP: begin
                psel     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                psel      = 1'b1;
                pen       = 1'b1;
                done      = pready || abort;
                // The completing cycle doubles as the next accept slot.
                cmd_ready = done && !preset;
                accept    = cmd_valid && cmd_ready;
                if (done)
                    state_nx = accept ? SETUP : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= done;
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            // pwrite still describes the finishing transfer here.
            if (done && !abort && !pwrite)
                rsp_rdata <= prdata;
            else
                rsp_rdata <= '0;
        end
    end

endmodule
